// File: rtl/eeg_pkg.sv
// eeg_pkg: shared FSM encoding, default widths and config register indices for eeg_dat_parser
package eeg_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CMD_ADDR = 2'd1, CMD_DATA = 2'd2, DAT = 2'd3} state_t;
  localparam int DAT_DW_DEF = 8;
  localparam int SMP_DW_DEF = 16;
  localparam int REG_CTRL = 0;
  localparam int REG_CH_EN = 1;
endpackage

// File: rtl/eeg_smp_pack.sv
// eeg_smp_pack: little-endian byte-lane assembly into a registered valid/ready sample (pad flag under EEG_PARSER_ERR_EN)
module eeg_smp_pack import eeg_pkg::*; #(
  parameter int DAT_DW = DAT_DW_DEF,
  parameter int SMP_DW = SMP_DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              lst,
  input  logic [DAT_DW-1:0] dat,
  input  logic              smp_rdy,
  output logic              rdy,
  output logic              smp_vld,
  output logic              smp_lst,
  output logic [SMP_DW-1:0] smp_dat
`ifdef EEG_PARSER_ERR_EN
  ,
  output logic              pad
`endif
);
  localparam int NB = SMP_DW / DAT_DW;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  logic [BW-1:0] bcnt;
  logic [SMP_DW-1:0] acc, acc_n;
  logic done;
  always_comb begin
    acc_n = acc | (SMP_DW'(dat) << (int'(bcnt) * DAT_DW));
    done = beat && (lst || bcnt == BW'(NB - 1));
    rdy = !smp_vld || smp_rdy;
  end
`ifdef EEG_PARSER_ERR_EN
  assign pad = beat && lst && bcnt != BW'(NB - 1);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
      acc <= '0;
      smp_vld <= 1'b0;
      smp_lst <= 1'b0;
      smp_dat <= '0;
    end else begin
      if (done) begin
        smp_dat <= acc_n;
        smp_lst <= lst;
        bcnt <= '0;
        acc <= '0;
      end else if (beat) begin
        acc <= acc_n;
        bcnt <= bcnt + 1'b1;
      end
      smp_vld <= done || (smp_vld && !smp_rdy);
    end
  end
endmodule

// File: rtl/eeg_dat_parser.sv
// eeg_dat_parser: byte-stream parser feeding a config register bank and packed EEG samples; sticky err port under EEG_PARSER_ERR_EN
module eeg_dat_parser import eeg_pkg::*; #(
  parameter int DAT_DW  = DAT_DW_DEF,
  parameter int SMP_DW  = SMP_DW_DEF,
  parameter int NUM_REG = 8,
  parameter int REG_AW  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic                      in_lst,
  output logic                      in_rdy,
  input  logic [DAT_DW-1:0]         in_dat,
  input  logic                      in_cmd,
  output logic                      smp_vld,
  output logic                      smp_lst,
  input  logic                      smp_rdy,
  output logic [SMP_DW-1:0]         smp_dat,
  output logic [NUM_REG*DAT_DW-1:0] cfg_reg,
  output logic                      busy
`ifdef EEG_PARSER_ERR_EN
  ,
  output logic                      err
`endif
);
  state_t state, state_n;
  logic [REG_AW-1:0] wr_ptr;
  logic [NUM_REG-1:0][DAT_DW-1:0] cfg;
  logic pk_rdy, beat, dat_beat;
  assign cfg_reg = cfg;
  assign busy = state != IDLE;
  always_comb begin
    in_rdy = state == CMD_DATA ? 1'b1 : state == DAT ? pk_rdy : state == IDLE ? (in_cmd || pk_rdy) : 1'b0;
    beat = in_vld && in_rdy;
    dat_beat = beat && (state == DAT || (state == IDLE && !in_cmd));
    state_n = state == IDLE ? (beat && !in_lst ? (in_cmd ? CMD_DATA : DAT) : IDLE)
            : (state == CMD_DATA || state == DAT) ? (beat && in_lst ? IDLE : state)
            : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      cfg <= '0;
    end else if (beat && state == IDLE && in_cmd) begin
      wr_ptr <= in_dat[REG_AW-1:0];
    end else if (beat && state == CMD_DATA) begin
      cfg[wr_ptr] <= in_dat;
      wr_ptr <= wr_ptr == REG_AW'(NUM_REG - 1) ? '0 : wr_ptr + 1'b1;
    end
  end
`ifdef EEG_PARSER_ERR_EN
  logic pk_pad;
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (pk_pad || (beat && ((state == CMD_DATA && !in_cmd) || (state == DAT && in_cmd)))) err <= 1'b1;
  end
`endif
  eeg_smp_pack #(.DAT_DW(DAT_DW), .SMP_DW(SMP_DW)) u_pack (
    .clk(clk),
    .rst(rst),
    .beat(dat_beat),
    .lst(in_lst),
    .dat(in_dat),
    .smp_rdy(smp_rdy),
    .rdy(pk_rdy),
    .smp_vld(smp_vld),
    .smp_lst(smp_lst),
    .smp_dat(smp_dat)
`ifdef EEG_PARSER_ERR_EN
    ,
    .pad(pk_pad)
`endif
  );
endmodule
